// File: rtl/fifo_cam.sv
// Synchronous single-clock FIFO for 17-bit camera words (bit 16 = command flag, passed through untouched).
// Registered read word and registered Empty/Full/Wnum status; no combinational input-to-output path.
module fifo_cam #(
    parameter int DATA_WIDTH = 17,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  WrEn,
    input  logic                  RdEn,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Empty,
    output logic                  Full,
    output logic [ADDR_WIDTH:0]   Wnum
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   wnum_q, wnum_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  wr_acc;
    logic                  rd_acc;

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no latch can be inferred.
        wr_acc   = WrEn & ~full_q;
        rd_acc   = RdEn & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_d      = q_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            q_d      = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end

        // Extra pointer MSB makes the difference span 0..DEPTH without ambiguity.
        wnum_d  = wr_ptr_d - rd_ptr_d;
        empty_d = (wnum_d == '0);
        full_d  = (wnum_d == DEPTH_CNT);
    end

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wnum_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wnum_q   <= wnum_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            q_q      <= q_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers alone define valid contents.
    always_ff @(posedge Clk) begin
        if (wr_acc && !Reset) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= Data;
        end
    end

    assign Q     = q_q;
    assign Empty = empty_q;
    assign Full  = full_q;
    assign Wnum  = wnum_q;

endmodule

// File: tb/tb_fifo_cam.sv
// Self-checking bench for fifo_cam: driver keeps a reference queue and pushes expected read words
// into a scoreboard; a negedge monitor pops and compares Q and checks Wnum/Empty/Full every cycle.
module tb_fifo_cam;

    localparam int DW    = 17;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] Data;
    logic          WrEn;
    logic          RdEn;
    logic [DW-1:0] Q;
    logic          Empty;
    logic          Full;
    logic [AW:0]   Wnum;

    fifo_cam #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Data  (Data),
        .WrEn  (WrEn),
        .RdEn  (RdEn),
        .Q     (Q),
        .Empty (Empty),
        .Full  (Full),
        .Wnum  (Wnum)
    );

    always #5 Clk = ~Clk;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model [$];   // reference contents of the FIFO
    logic [DW-1:0] sb_q [$];    // expected words for Q, one per accepted read
    logic          rd_event  = 1'b0;
    logic          rst_event = 1'b0;
    logic          mon_en    = 1'b0;
    logic          last_wr_acc = 1'b0;
    logic [DW-1:0] q_hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
        logic rd_acc;
        logic wr_acc;
        Reset = 1'b0;
        WrEn  = wr;
        RdEn  = rd;
        Data  = d;
        @(posedge Clk);
        rd_acc = rd && (model.size() > 0);
        wr_acc = wr && (model.size() < DEPTH);
        rst_event   = 1'b0;
        rd_event    = rd_acc;
        last_wr_acc = wr_acc;
        if (rd_acc) sb_q.push_back(model.pop_front());
        if (wr_acc) model.push_back(d);
        @(negedge Clk);
    endtask

    task automatic reset_cycle(input logic wr, input logic rd, input logic [DW-1:0] d);
        Reset = 1'b1;
        WrEn  = wr;
        RdEn  = rd;
        Data  = d;
        mon_en = 1'b1;
        @(posedge Clk);
        model.delete();
        rst_event   = 1'b1;
        rd_event    = 1'b0;
        last_wr_acc = 1'b0;
        @(negedge Clk);
    endtask

    // Monitor: compares DUT outputs against the scoreboard and reference count each cycle.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (rst_event) begin
                q_hold = '0;
            end else if (rd_event) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    q_hold = sb_q.pop_front();
                end
            end
            check("q", 32'(Q), 32'(q_hold));
            check("wnum", 32'(Wnum), 32'(model.size()));
            check("empty", 32'(Empty), 32'(model.size() == 0));
            check("full", 32'(Full), 32'(model.size() == DEPTH));
        end
    end

    logic [DW-1:0] frame_d [16] = '{17'h01234, 17'h0FFFF, 17'h00000, 17'h0A5A5,
                                    17'h05A5A, 17'h08001, 17'h07FFE, 17'h0BEEF,
                                    17'h0CAFE, 17'h00F0F, 17'h0F0F0, 17'h01111,
                                    17'h02222, 17'h0DEAD, 17'h00042, 17'h09999};

    initial begin
        int written;
        Reset = 1'b1;
        WrEn  = 1'b0;
        RdEn  = 1'b0;
        Data  = '0;

        // Power-up reset
        reset_cycle(1'b0, 1'b0, '0);
        check("init_empty", 32'(Empty), 32'd1);
        check("init_wnum", 32'(Wnum), 32'd0);

        // Frame order: SOF marker then 16 pixels, one write every two clocks
        cycle(1'b1, 1'b0, 17'h10000);
        cycle(1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, frame_d[i]);
            cycle(1'b0, 1'b0, '0);
        end
        check("frame_wnum", 32'(Wnum), 32'd17);
        check("frame_empty", 32'(Empty), 32'd0);
        cycle(1'b0, 1'b1, '0);
        check("frame_sof", 32'(Q), 32'h10000);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0);
        check("frame_last", 32'(Q), 32'h09999);
        check("frame_drained", 32'(Empty), 32'd1);

        // Read on empty holds Q
        cycle(1'b1, 1'b0, 17'h0ABCD);
        cycle(1'b0, 1'b1, '0);
        check("abcd_read", 32'(Q), 32'h0ABCD);
        cycle(1'b0, 1'b1, '0);
        check("empty_read_q", 32'(Q), 32'h0ABCD);
        check("empty_read_wnum", 32'(Wnum), 32'd0);

        // Simultaneous write+read on empty: only the write lands
        cycle(1'b1, 1'b1, 17'h00055);
        check("sim_empty_wnum", 32'(Wnum), 32'd1);
        check("sim_empty_q", 32'(Q), 32'h0ABCD);
        cycle(1'b0, 1'b1, '0);
        check("sim_empty_next", 32'(Q), 32'h00055);

        // Fill to full, overflow write, simultaneous at full and at mid-level
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 17'(i));
        check("full_flag", 32'(Full), 32'd1);
        check("full_wnum", 32'(Wnum), 32'd1024);
        cycle(1'b1, 1'b0, 17'h1FFFF);
        check("overflow_wnum", 32'(Wnum), 32'd1024);
        cycle(1'b1, 1'b1, 17'h1FFFF);
        check("sim_full_wnum", 32'(Wnum), 32'd1023);
        check("sim_full_flag", 32'(Full), 32'd0);
        check("sim_full_q", 32'(Q), 32'd0);
        cycle(1'b1, 1'b1, 17'h00123);
        check("sim_mid_wnum", 32'(Wnum), 32'd1023);
        check("sim_mid_q", 32'(Q), 32'd1);
        for (int i = 0; i < 1023; i++) cycle(1'b0, 1'b1, '0);
        check("drain_q", 32'(Q), 32'h00123);
        check("drain_empty", 32'(Empty), 32'd1);

        // Reset mid-traffic, with WrEn/RdEn asserted in the reset cycle
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 17'h10000 | 17'(i));
        cycle(1'b0, 1'b1, '0);
        reset_cycle(1'b1, 1'b1, 17'h03333);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_wnum", 32'(Wnum), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        cycle(1'b0, 1'b1, '0);
        check("rst_read_q", 32'(Q), 32'd0);
        check("rst_read_wnum", 32'(Wnum), 32'd0);

        // Wrap-around: 3000 words with ~50% random WrEn/RdEn, then drain
        written = 0;
        for (int c = 0; c < 20000 && (written < 3000 || model.size() > 0); c++) begin
            cycle((written < 3000) && ($urandom_range(1) == 1),
                  $urandom_range(1) == 1,
                  17'(written * 37 + 5));
            if (last_wr_acc) written++;
        end
        check("wrap_written", 32'(written), 32'd3000);
        check("wrap_model_empty", 32'(model.size()), 32'd0);

        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
